// File: rtl/video_pkg.sv
// video_pkg: FSM encoding, column-mode offset widths and ROM address helper
package video_pkg;
  typedef enum logic [1:0] {IDLE, VRAM, ROM, READY} state_t;
  localparam int OFF40_W = 10;
  localparam int OFF80_W = 11;
  function automatic logic [7:0] rom_char(input logic gfx, input logic [7:0] code);
    return {gfx, code[6:0]};
  endfunction
endpackage

// File: rtl/video_pixel_gen_shifter.sv
// video_shifter: pixel shift register with latched invert/enable and registered video output
module video_shifter #(
  parameter int CHAR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [CHAR_WIDTH-1:0] data_i,
  input  logic                  inv_i,
  input  logic                  de_i,
  output logic                  video_o
);
  logic [CHAR_WIDTH-1:0] sh_q;
  logic inv_q, de_q, video_q;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      sh_q    <= '0;
      inv_q   <= 1'b0;
      de_q    <= 1'b0;
      video_q <= 1'b0;
    end else begin
      sh_q    <= load_i ? data_i : shift_i ? {sh_q[CHAR_WIDTH-2:0], 1'b0} : sh_q;
      inv_q   <= load_i ? inv_i : inv_q;
      de_q    <= load_i ? de_i : de_q;
      video_q <= de_q & (sh_q[CHAR_WIDTH-1] ^ inv_q);
    end
  assign video_o = video_q;
endmodule

// File: rtl/video_pixel_gen.sv
// video_pixel_gen: fetches character code then ROM row per slot and serialises pixels one slot later
module video_pixel_gen
  import video_pkg::*;
#(
  parameter int                 CHAR_WIDTH = 8,
  parameter int                 ROW_BITS   = 3,
  parameter int                 VRAM_AW    = 17,
  parameter logic [VRAM_AW-1:0] VRAM_BASE  = 17'h08000,
  parameter int                 ROM_AW     = 11
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  char_en_i,
  input  logic                  pix_en_i,
  input  logic                  cols80_i,
  input  logic                  gfx_i,
  input  logic                  de_i,
  input  logic [13:0]           ma_i,
  input  logic [4:0]            ra_i,
  output logic                  vram_req_o,
  output logic [VRAM_AW-1:0]    vram_addr_o,
  input  logic                  vram_ack_i,
  input  logic [7:0]            vram_data_i,
  output logic                  rom_req_o,
  output logic [ROM_AW-1:0]     rom_addr_o,
  input  logic                  rom_ack_i,
  input  logic [CHAR_WIDTH-1:0] rom_data_i,
  output logic                  video_o,
  output logic                  underrun_o
);
  state_t state_q, state_d;
  logic cap_de_q, cap_de_d, gfx_q, gfx_d, hold_q, hold_d, inv_q, inv_d;
  logic pend_inv_q, pend_inv_d, pend_de_q, pend_de_d, under_q, under_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [VRAM_AW-1:0] vaddr_q, vaddr_d, offset;
  logic [ROM_AW-1:0] raddr_q, raddr_d;
  logic [CHAR_WIDTH-1:0] pend_q, pend_d;
  logic late;
  logic unused_bits;
  assign unused_bits = ^{ma_i[13:OFF80_W], ra_i[4:ROW_BITS]};
  assign late   = char_en_i && (state_q == VRAM || state_q == ROM);
  assign offset = cols80_i ? VRAM_AW'(ma_i[OFF80_W-1:0]) : VRAM_AW'(ma_i[OFF40_W-1:0]);
  // hold_q keeps the request low for one cycle after an abandoned fetch
  always_comb begin
    state_d    = state_q;
    cap_de_d   = cap_de_q;
    gfx_d      = gfx_q;
    row_d      = row_q;
    hold_d     = 1'b0;
    inv_d      = inv_q;
    vaddr_d    = vaddr_q;
    raddr_d    = raddr_q;
    pend_d     = pend_q;
    pend_inv_d = pend_inv_q;
    pend_de_d  = pend_de_q;
    under_d    = late;
    if (char_en_i) begin
      cap_de_d   = de_i;
      gfx_d      = gfx_i;
      row_d      = ra_i[ROW_BITS-1:0];
      vaddr_d    = VRAM_BASE + offset;
      pend_d     = '0;
      pend_inv_d = 1'b0;
      pend_de_d  = 1'b0;
      hold_d     = late && de_i;
      state_d    = de_i ? VRAM : READY;
    end else if (state_q == VRAM && !hold_q && vram_ack_i) begin
      inv_d   = vram_data_i[7];
      raddr_d = {rom_char(gfx_q, vram_data_i), row_q};
      state_d = ROM;
    end else if (state_q == ROM && rom_ack_i) begin
      pend_d     = rom_data_i;
      pend_inv_d = inv_q;
      pend_de_d  = cap_de_q;
      state_d    = READY;
    end
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q    <= IDLE;
      cap_de_q   <= 1'b0;
      gfx_q      <= 1'b0;
      row_q      <= '0;
      hold_q     <= 1'b0;
      inv_q      <= 1'b0;
      vaddr_q    <= '0;
      raddr_q    <= '0;
      pend_q     <= '0;
      pend_inv_q <= 1'b0;
      pend_de_q  <= 1'b0;
      under_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_de_q   <= cap_de_d;
      gfx_q      <= gfx_d;
      row_q      <= row_d;
      hold_q     <= hold_d;
      inv_q      <= inv_d;
      vaddr_q    <= vaddr_d;
      raddr_q    <= raddr_d;
      pend_q     <= pend_d;
      pend_inv_q <= pend_inv_d;
      pend_de_q  <= pend_de_d;
      under_q    <= under_d;
    end
  assign vram_req_o  = state_q == VRAM && !hold_q;
  assign rom_req_o   = state_q == ROM;
  assign vram_addr_o = vaddr_q;
  assign rom_addr_o  = raddr_q;
  assign underrun_o  = under_q;
  video_shifter #(.CHAR_WIDTH(CHAR_WIDTH)) u_shifter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (char_en_i),
    .shift_i (pix_en_i),
    .data_i  (late ? '0 : pend_q),
    .inv_i   (!late && pend_inv_q),
    .de_i    (!late && pend_de_q),
    .video_o (video_o)
  );
endmodule

// File: tb/tb_video_pixel_gen.sv
// tb_video_pixel_gen: randomized slots with memory responders, checked every cycle against a slot-level model
module tb_video_pixel_gen;
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic reset_i = 1'b1, char_en_i = 1'b0, pix_en_i = 1'b0, cols80_i = 1'b0, gfx_i = 1'b0, de_i = 1'b0;
  logic [13:0] ma_i = '0;
  logic [4:0] ra_i = '0;
  logic vram_req_o, vram_ack_i, rom_req_o, rom_ack_i, video_o, underrun_o;
  logic [16:0] vram_addr_o;
  logic [10:0] rom_addr_o;
  logic [7:0] vram_data_i, rom_data_i;
  video_pixel_gen dut (
    .clk_i(clk_i), .reset_i(reset_i), .char_en_i(char_en_i), .pix_en_i(pix_en_i),
    .cols80_i(cols80_i), .gfx_i(gfx_i), .de_i(de_i), .ma_i(ma_i), .ra_i(ra_i),
    .vram_req_o(vram_req_o), .vram_addr_o(vram_addr_o), .vram_ack_i(vram_ack_i), .vram_data_i(vram_data_i),
    .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o), .rom_ack_i(rom_ack_i), .rom_data_i(rom_data_i),
    .video_o(video_o), .underrun_o(underrun_o)
  );
  logic [7:0] vram_mem [0:131071];
  logic [7:0] rom_mem [0:2047];
  int n_vec = 0, n_err = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  // memory responders: ack after a per-request delay, garbage data otherwise
  logic resp_vack = 1'b0, resp_rack = 1'b0, stale_ack = 1'b0;
  logic [7:0] resp_vdata = '0, resp_rdata = '0;
  int vdly = 0, rdly = 0, vcnt = 0, rcnt = 0, vlim = 0, rlim = 0;
  bit rand_dly = 1'b0;
  assign vram_ack_i  = resp_vack;
  assign vram_data_i = resp_vdata;
  assign rom_ack_i   = resp_rack | stale_ack;
  assign rom_data_i  = stale_ack ? 8'hFF : resp_rdata;
  function automatic int pick(input int fixed);
    if (!rand_dly) return fixed;
    return ($urandom_range(0, 9) == 0) ? 14 : int'($urandom_range(0, 3));
  endfunction
  always @(negedge clk_i) begin
    resp_vack  = 1'b0;
    resp_rack  = 1'b0;
    resp_vdata = 8'($urandom);
    resp_rdata = 8'($urandom);
    if (!vram_req_o) begin vcnt = 0; vlim = pick(vdly); end
    else if (vcnt >= vlim) begin resp_vack = 1'b1; resp_vdata = vram_mem[vram_addr_o]; vcnt = 0; end
    else vcnt++;
    if (!rom_req_o) begin rcnt = 0; rlim = pick(rdly); end
    else if (rcnt >= rlim) begin resp_rack = 1'b1; resp_rdata = rom_mem[rom_addr_o]; rcnt = 0; end
    else rcnt++;
  end
  // slot-level model: what each slot must display, derived from memory contents at capture time
  bit cap_valid, cap_de, cap_inv, done, cur_de, cur_inv, exp_video, exp_under, m_busy;
  logic [7:0] cap_pix, cur_pix, m_code;
  logic [16:0] cap_vaddr;
  logic [10:0] cap_raddr, m_off;
  int k;
  always @(posedge clk_i) begin
    if (reset_i) begin
      cap_valid = 0; cap_de = 0; cap_inv = 0; done = 0; cur_de = 0; cur_inv = 0;
      exp_video = 0; exp_under = 0; cap_pix = 0; cur_pix = 0; k = 0;
    end else begin
      m_busy    = cap_valid && cap_de && !done;
      exp_video = cur_de & ((k < 8 ? cur_pix[7 - k] : 1'b0) ^ cur_inv);
      exp_under = char_en_i && m_busy;
      if (char_en_i) begin
        cur_de    = !m_busy && cap_valid && cap_de;
        cur_pix   = cap_pix;
        cur_inv   = cur_de && cap_inv;
        k         = 0;
        m_off     = cols80_i ? ma_i[10:0] : {1'b0, ma_i[9:0]};
        cap_valid = 1;
        cap_de    = de_i;
        cap_vaddr = 17'h08000 + 17'(m_off);
        m_code    = vram_mem[cap_vaddr];
        cap_raddr = {gfx_i, m_code[6:0], ra_i[2:0]};
        cap_pix   = rom_mem[cap_raddr];
        cap_inv   = m_code[7];
        done      = 0;
      end else begin
        if (pix_en_i && k < 100) k++;
        if (rom_ack_i && m_busy) done = 1;
      end
    end
  end
  always @(negedge clk_i) begin
    if (reset_i) begin
      chk("rst_video", 32'(video_o), 0);
      chk("rst_underrun", 32'(underrun_o), 0);
      chk("rst_vram_req", 32'(vram_req_o), 0);
      chk("rst_rom_req", 32'(rom_req_o), 0);
    end else begin
      chk("video", 32'(video_o), 32'(exp_video));
      chk("underrun", 32'(underrun_o), 32'(exp_under));
      if (vram_req_o) begin
        chk("vram_req_allowed", 32'(cap_valid && cap_de && !done), 1);
        chk("vram_addr", 32'(vram_addr_o), 32'(cap_vaddr));
      end
      if (rom_req_o) begin
        chk("rom_req_allowed", 32'(cap_valid && cap_de && !done && !vram_req_o), 1);
        chk("rom_addr", 32'(rom_addr_o), 32'(cap_raddr));
      end
    end
  end
  logic [7:0] seen_pix;
  int seen_under;
  bit seen_vreq, seen_rreq;
  logic [16:0] seen_vaddr;
  logic [10:0] seen_raddr;
  task automatic slot(input bit de, input logic [13:0] ma, input logic [4:0] ra, input bit gfx,
                      input bit c80, input int vd, input int rd, input int npix, input int len);
    @(negedge clk_i);
    vdly = vd;
    rdly = rd;
    @(negedge clk_i);
    char_en_i = 1; pix_en_i = 0; de_i = de; ma_i = ma; ra_i = ra; gfx_i = gfx; cols80_i = c80;
    seen_pix = 0; seen_under = 0; seen_vreq = 0; seen_rreq = 0; seen_vaddr = '1; seen_raddr = '1;
    for (int j = 1; j < len; j++) begin
      @(negedge clk_i);
      if (j >= 2 && j - 2 < 8 && j - 2 < npix) seen_pix[9 - j] = video_o;
      seen_under += int'(underrun_o);
      if (vram_req_o && !seen_vreq) begin seen_vreq = 1; seen_vaddr = vram_addr_o; end
      if (rom_req_o && !seen_rreq) begin seen_rreq = 1; seen_raddr = rom_addr_o; end
      char_en_i = 0;
      pix_en_i  = j <= npix;
      de_i = 1'($urandom); ma_i = 14'($urandom); ra_i = 5'($urandom); gfx_i = 1'($urandom); cols80_i = 1'($urandom);
    end
    pix_en_i = 0;
  endtask
  int np;
  initial begin
    for (int a = 0; a < 2048; a++) begin
      vram_mem[17'h08000 + a] = 8'($urandom);
      rom_mem[a] = 8'($urandom);
    end
    repeat (3) @(negedge clk_i);
    reset_i = 0;
    @(negedge clk_i);
    chk("reset_state_video", 32'(video_o), 0);
    chk("reset_state_vreq", 32'(vram_req_o), 0);
    chk("reset_state_vaddr", 32'(vram_addr_o), 0);
    chk("reset_state_raddr", 32'(rom_addr_o), 0);
    vram_mem[17'h08005] = 8'h41;
    rom_mem[11'h20A] = 8'hA5;
    slot(1, 14'h005, 5'd2, 0, 0, 0, 0, 8, 12);
    chk("basic_vaddr", 32'(seen_vaddr), 32'h08005);
    chk("basic_raddr", 32'(seen_raddr), 32'h20A);
    vram_mem[17'h08005] = 8'hC1;
    slot(0, 14'h005, 5'd2, 0, 0, 0, 0, 8, 12);
    chk("basic_pixels", 32'(seen_pix), 32'hA5);
    chk("de0_no_vram_req", 32'(seen_vreq), 0);
    slot(1, 14'h005, 5'd2, 0, 0, 1, 2, 8, 12);
    chk("de0_pixels", 32'(seen_pix), 0);
    slot(1, 14'h07FF, 5'd0, 1, 1, 0, 0, 10, 13);
    chk("reverse_pixels", 32'(seen_pix), 32'h5A);
    chk("c80_vaddr", 32'(seen_vaddr), 32'h087FF);
    chk("gfx1_rom_msb", 32'(seen_raddr[10]), 1);
    slot(1, 14'h07FF, 5'd0, 0, 0, 0, 0, 8, 12);
    chk("c40_vaddr", 32'(seen_vaddr), 32'h083FF);
    chk("gfx0_rom_msb", 32'(seen_raddr[10]), 0);
    vram_mem[17'h08006] = 8'h42;
    rom_mem[{1'b0, 7'h42, 3'd1}] = 8'hFF;
    slot(1, 14'h006, 5'd1, 0, 0, 30, 0, 8, 12);
    chk("late_slot_no_underrun", 32'(seen_under), 0);
    slot(1, 14'h005, 5'd2, 0, 0, 0, 0, 8, 12);
    chk("underrun_pulse", 32'(seen_under), 1);
    chk("underrun_blank", 32'(seen_pix), 0);
    slot(1, 14'h020, 5'd3, 0, 0, 0, 0, 8, 12);
    chk("after_underrun_pixels", 32'(seen_pix), 32'h5A);
    chk("after_underrun_none", 32'(seen_under), 0);
    @(negedge clk_i);
    rdly = 30;
    @(negedge clk_i);
    char_en_i = 1; de_i = 1; ma_i = 14'h030; ra_i = 5'd4;
    @(negedge clk_i);
    char_en_i = 0;
    repeat (3) @(negedge clk_i);
    chk("mid_rom_fetch", 32'(rom_req_o), 1);
    #2 reset_i = 1;
    #1;
    chk("async_rst_video", 32'(video_o), 0);
    chk("async_rst_rom_req", 32'(rom_req_o), 0);
    chk("async_rst_raddr", 32'(rom_addr_o), 0);
    repeat (2) @(negedge clk_i);
    reset_i = 0;
    @(negedge clk_i);
    stale_ack = 1;
    @(negedge clk_i);
    stale_ack = 0;
    rdly = 0;
    slot(1, 14'h005, 5'd2, 0, 0, 0, 0, 8, 12);
    chk("stale_ack_blank", 32'(seen_pix), 0);
    chk("stale_ack_no_underrun", 32'(seen_under), 0);
    slot(0, 14'h005, 5'd2, 0, 0, 0, 0, 8, 12);
    chk("post_reset_pixels", 32'(seen_pix), 32'h5A);
    rand_dly = 1;
    for (int s = 0; s < 300; s++) begin
      np = int'($urandom_range(0, 10));
      slot($urandom_range(0, 4) != 0, 14'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
           0, 0, np, np + 2 + int'($urandom_range(0, 4)));
    end
    repeat (4) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of stimulus");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/video_pixel_gen.md
Name: video_pixel_gen

Overview:
- Parametrised successor to the PET video path: it fetches the character code, then the character-ROM row, and serialises the pixels.
- Today the path only passes CRTC display-enable to the output. This block instead drives real pixels.
- Sits between the crtc block (ma/ra/de) and the video output pin.
- Memory is reached over two independent req/ack read ports, one for VRAM and one for character ROM. It supports a 40/80-column mode, graphics/text ROM bank select and reverse video.

Parameters:
- CHAR_WIDTH, 8, pixels per character cell; also the width of the ROM data.
- ROW_BITS, 3, number of ra bits used as the ROM row index.
- VRAM_AW, 17, VRAM address width.
- VRAM_BASE, 17'h08000, VRAM base address. The character offset is added to it.
- ROM_AW, 11, char ROM address width; must equal 1+7+ROW_BITS.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous, active-high reset
- char_en_i  in  1  one-cycle strobe that starts a character slot
- pix_en_i  in  1  one-cycle pixel strobe, CHAR_WIDTH per slot
- cols80_i  in  1  1 = 80-column mode: VRAM offset is ma[10:0], otherwise ma[9:0]
- gfx_i  in  1  selects the ROM bank (address MSB)
- de_i  in  1  CRTC display enable
- ma_i  in  14  CRTC memory address
- ra_i  in  5  CRTC raster address
- vram_req_o  out  1  VRAM read request
- vram_addr_o  out  VRAM_AW  VRAM address
- vram_ack_i  in  1  VRAM data valid (one cycle)
- vram_data_i  in  8  character code
- rom_req_o  out  1  ROM read request
- rom_addr_o  out  ROM_AW  ROM address
- rom_ack_i  in  1  ROM data valid (one cycle)
- rom_data_i  in  CHAR_WIDTH  pixel row
- video_o  out  1  pixel output
- underrun_o  out  1  one-cycle pulse when a fetch is late

Behaviour:
- Reset values: all outputs 0; FSM IDLE; shift register, pending register and all flags 0.
- The reset is asynchronous, so it aborts any in-flight fetch. An ack arriving after reset is ignored.
- FSM states: IDLE, VRAM, ROM, READY.
- IDLE / READY on char_en_i (a new slot starts):
  - Capture de_i, ra_i[ROW_BITS-1:0], gfx_i and the offset into fetch registers.
  - Offset: ma_i[10:0] in 80-column mode, {1'b0, ma_i[9:0]} in 40-column mode.
  - vram_addr_o = VRAM_BASE + offset, truncated to VRAM_AW bits (wrap, no saturation).
  - Go to VRAM. If the captured de is 0, go to READY directly with pending data = 0 and no request.
- VRAM:
  - vram_req_o is held high and the address stays stable until vram_ack_i.
  - On ack: drop the request the same edge, latch invert = data[7], rom_addr_o = {gfx, data[6:0], row}, go to ROM.
- ROM:
  - rom_req_o is held high until rom_ack_i.
  - On ack: pending = rom_data_i, pending_inv = invert, pending_de = captured de; go to READY.
- Output pipeline, at each char_en_i:
  - Shift register <= pending, inv_r <= pending_inv, de_r <= pending_de. This happens before the new fetch captures.
  - This gives a fixed latency of exactly one character slot from ma/ra to pixels.
  - On each pix_en_i the shift register shifts left, filling with 0.
  - video_o = de_r & (shift[CHAR_WIDTH-1] ^ inv_r), registered.
- Underrun: if char_en_i arrives while the FSM is in VRAM or ROM:
  - underrun_o pulses for one cycle; the output loads blank (shift 0, inv 0, de 0).
  - The in-flight fetch is abandoned: the request drops for one cycle, then a new fetch starts for the new slot. Late acks are ignored.
- Simultaneous char_en_i and pix_en_i: the load wins, with no shift that cycle.
- More than CHAR_WIDTH pix_en_i strobes in a slot: zeros shift out, giving blank pixels. The output stays correct.
- Clock enables are single-cycle. The req/ack ports allow any number of wait cycles, including an ack in the cycle after the request.

Decomposition:
- Package video_pkg holds:
  - the FSM state enum;
  - constants for the 40/80-column offset widths;
  - a helper function building the ROM address.
- One natural sub-module, video_shifter: the CHAR_WIDTH shift register plus inv/de flops and the output register.

Test Plan:
- 40-column mode, ma=0x005, ra=2, VRAM[0x8005]=0x41, ROM[{0,0x41,2}]=0xA5, immediate acks:
  - vram_addr_o = 0x08005, rom_addr_o = 0x20A;
  - the next slot's 8 pix_en_i produce 1,0,1,0,0,1,0,1.
- Reverse video: VRAM data = 0xC1, ROM row 0xA5 -> pixels 0,1,0,1,1,0,1,0.
- 80-column mode, ma=0x7FF -> vram_addr_o = 0x087FF. 40-column mode with the same ma -> 0x083FF. gfx_i=1 sets the ROM address MSB.
- de_i=0 at capture -> no vram_req_o; the next slot outputs eight 0s even when invert data is present.
- VRAM ack delayed past the next char_en_i -> one underrun_o pulse; that slot outputs blank; the following fetch completes and displays correctly.
- reset_i asserted mid-ROM fetch -> all outputs 0 asynchronously; a stale rom_ack_i after release causes no pending update.
